// File: rtl/flag_event_queue_pkg.sv
// Shared types and constants for the flag event queue.
package flag_event_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } flag_event_state_e;

    // Widths of the optional statistics counters.
    localparam int unsigned TOTAL_W = 16;
    localparam int unsigned DROP_W  = 8;

endpackage

// File: rtl/flag_event_queue_if.sv
// Event-side bundle of the flag event queue.
// With FLAG_EVENT_QUEUE_STATS_EN defined it also carries the statistics outputs.
interface flag_event_queue_if
    import flag_event_pkg::*;
#(
    parameter int unsigned CNT_W = 4
);
    logic             flag_in;
    logic             clear;
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] pending;
    logic             overflow;
`ifdef FLAG_EVENT_QUEUE_STATS_EN
    logic [TOTAL_W-1:0] total_events;
    logic [DROP_W-1:0]  drop_count;
`endif

    // The queue side drives the event offer and the status.
    modport master (
        input  flag_in, clear, evt_ready,
        output evt_valid, pending, overflow
`ifdef FLAG_EVENT_QUEUE_STATS_EN
        , output total_events, drop_count
`endif
    );

    // The producer/consumer side.
    modport slave (
        output flag_in, clear, evt_ready,
        input  evt_valid, pending, overflow
`ifdef FLAG_EVENT_QUEUE_STATS_EN
        , input total_events, drop_count
`endif
    );
endinterface

// File: rtl/flag_event_queue.sv
// Buffers crossed flag pulses as a saturating count and hands them out one at a
// time over valid/ready, with HOLDOFF idle cycles forced after each accept.
// Optional statistics outputs: FLAG_EVENT_QUEUE_STATS_EN.
module flag_event_queue
    import flag_event_pkg::*;
#(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    flag_event_queue_if.master  bus
);
    // Gap counter is loaded with HOLDOFF-1 and counts down to zero.
    localparam int unsigned GAP_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam int unsigned GAP_W    = (GAP_LOAD == 0) ? 1 : $clog2(GAP_LOAD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    flag_event_state_e state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              accept;
    logic              drop;

    assign accept = (state_q == OFFER) && bus.evt_ready;

    // Pending count and sticky overflow; clear wins over flag and accept.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        drop       = 1'b0;
        if (bus.clear) begin
            pending_d  = '0;
            overflow_d = 1'b0;
        end else if (bus.flag_in && !accept) begin
            if (pending_q == CNT_MAX) begin
                overflow_d = 1'b1;
                drop       = 1'b1;
            end else begin
                pending_d = pending_q + CNT_W'(1);
            end
        end else if (accept && !bus.flag_in) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    // Next-state logic for the offer/holdoff sequencer.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        if (bus.clear) begin
            state_d = IDLE;
            gap_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pending_q != '0 || bus.flag_in) state_d = OFFER;
                end
                OFFER: begin
                    if (accept) begin
                        if (HOLDOFF > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_W'(GAP_LOAD);
                        end else begin
                            state_d = (pending_d != '0) ? OFFER : IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_d = (pending_d != '0) ? OFFER : IDLE;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    gap_d   = '0;
                end
            endcase
        end
    end

    // State, gap timer and counters; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        bus.evt_valid = (state_q == OFFER);
        bus.pending   = pending_q;
        bus.overflow  = overflow_q;
    end

`ifdef FLAG_EVENT_QUEUE_STATS_EN
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [DROP_W-1:0]  drops_q, drops_d;

    // Total wraps and ignores clear; drop count saturates and is flushed by clear.
    always_comb begin
        total_d = total_q + (bus.flag_in ? TOTAL_W'(1) : TOTAL_W'(0));
        drops_d = drops_q;
        if (bus.clear) begin
            drops_d = '0;
        end else if (drop && drops_q != {DROP_W{1'b1}}) begin
            drops_d = drops_q + DROP_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            total_q <= '0;
            drops_q <= '0;
        end else begin
            total_q <= total_d;
            drops_q <= drops_d;
        end
    end

    // Statistics outputs.
    always_comb begin
        bus.total_events = total_q;
        bus.drop_count   = drops_q;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule
